// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional second (skid) entry so that in_ready can be driven from a flop.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int WB_W   = 3,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   in_wb,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   out_wb,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_rd_eq0,
  output logic              out_reg_write,
  output logic [1:0]        occupancy
);

  localparam bit HAS_SKID = (SKID != 0);

  // Main entry M (drives the outputs) and skid entry S.
  logic              m_valid_q, m_valid_d;
  logic [WB_W-1:0]   m_wb_q,    m_wb_d;
  logic [RD_W-1:0]   m_rd_q,    m_rd_d;
  logic              m_eq0_q,   m_eq0_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;

  logic              s_valid_q, s_valid_d;
  logic [WB_W-1:0]   s_wb_q,    s_wb_d;
  logic [RD_W-1:0]   s_rd_q,    s_rd_d;
  logic              s_eq0_q,   s_eq0_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;

  logic accept;
  logic deliver;
  logic in_eq0;

  // With the skid entry, in_ready depends only on S so out_ready has no
  // combinational path to the upstream stage.
  assign in_ready = HAS_SKID ? !s_valid_q : (!m_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign deliver  = m_valid_q && out_ready;
  assign in_eq0   = (in_rd == '0);

  always_comb begin
    m_valid_d = m_valid_q;
    m_wb_d    = m_wb_q;
    m_rd_d    = m_rd_q;
    m_eq0_d   = m_eq0_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_wb_d    = s_wb_q;
    s_rd_d    = s_rd_q;
    s_eq0_d   = s_eq0_q;
    s_data_d  = s_data_q;

    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_wb_d    = '0;
      s_wb_d    = '0;
    end else if (s_valid_q && deliver) begin
      // S full implies in_ready=0, so no accept can coincide with this move.
      m_valid_d = 1'b1;
      m_wb_d    = s_wb_q;
      m_rd_d    = s_rd_q;
      m_eq0_d   = s_eq0_q;
      m_data_d  = s_data_q;
      s_valid_d = 1'b0;
    end else if (accept && (!m_valid_q || deliver)) begin
      m_valid_d = 1'b1;
      m_wb_d    = in_wb;
      m_rd_d    = in_rd;
      m_eq0_d   = in_eq0;
      m_data_d  = in_data;
    end else if (accept && HAS_SKID) begin
      s_valid_d = 1'b1;
      s_wb_d    = in_wb;
      s_rd_d    = in_rd;
      s_eq0_d   = in_eq0;
      s_data_d  = in_data;
    end else if (deliver) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_wb_q    <= '0;
      m_rd_q    <= '0;
      m_eq0_q   <= 1'b0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_wb_q    <= '0;
      s_rd_q    <= '0;
      s_eq0_q   <= 1'b0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_wb_q    <= m_wb_d;
      m_rd_q    <= m_rd_d;
      m_eq0_q   <= m_eq0_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_wb_q    <= s_wb_d;
      s_rd_q    <= s_rd_d;
      s_eq0_q   <= s_eq0_d;
      s_data_q  <= s_data_d;
    end
  end

  assign out_valid     = m_valid_q;
  assign out_wb        = m_wb_q;
  assign out_rd        = m_rd_q;
  assign out_data      = m_data_q;
  assign out_rd_eq0    = m_eq0_q;
  assign out_reg_write = m_valid_q && m_wb_q[0] && !m_eq0_q;
  assign occupancy     = {1'b0, m_valid_q} + {1'b0, s_valid_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: instance u_skid (SKID=1) and u_noskid (SKID=0) share clk/rst/flush.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [2:0]  in_wb = '0, out_wb;
  logic [4:0]  in_rd = '0, out_rd;
  logic [31:0] in_data = '0, out_data;
  logic        out_rd_eq0, out_reg_write;
  logic [1:0]  occupancy;

  logic        n_in_valid = 1'b0, n_in_ready, n_out_valid, n_out_ready = 1'b1;
  logic [2:0]  n_in_wb = '0, n_out_wb;
  logic [4:0]  n_in_rd = '0, n_out_rd;
  logic [31:0] n_in_data = '0, n_out_data;
  logic        n_out_rd_eq0, n_out_reg_write;
  logic [1:0]  n_occupancy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .RD_W(5), .WB_W(3), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_wb(in_wb), .in_rd(in_rd), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_wb(out_wb), .out_rd(out_rd),
    .out_data(out_data), .out_rd_eq0(out_rd_eq0), .out_reg_write(out_reg_write),
    .occupancy(occupancy)
  );

  pipe_stage_reg #(.DATA_W(32), .RD_W(5), .WB_W(3), .SKID(0)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_wb(n_in_wb), .in_rd(n_in_rd),
    .in_data(n_in_data), .out_valid(n_out_valid), .out_ready(n_out_ready), .out_wb(n_out_wb),
    .out_rd(n_out_rd), .out_data(n_out_data), .out_rd_eq0(n_out_rd_eq0),
    .out_reg_write(n_out_reg_write), .occupancy(n_occupancy)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    check_eq({pfx, "_valid"}, out_valid, 0);
    check_eq({pfx, "_wb"}, out_wb, 0);
    check_eq({pfx, "_rd"}, out_rd, 0);
    check_eq({pfx, "_data"}, out_data, 0);
    check_eq({pfx, "_eq0"}, out_rd_eq0, 0);
    check_eq({pfx, "_rw"}, out_reg_write, 0);
    check_eq({pfx, "_occ"}, occupancy, 0);
    check_eq({pfx, "_inrdy"}, in_ready, 1);
  endtask

  initial begin
    #2;
    check_reset("rst0");
    check_eq("rst0_n_inrdy", n_in_ready, 1);
    check_eq("rst0_n_valid", n_out_valid, 0);
    check_eq("rst0_n_occ", n_occupancy, 0);
    tick();
    rst = 1'b0;

    // Streaming, SKID=1, out_ready=1.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h1000 + 32'(i);
      in_rd    = 5'(i + 1);
      in_wb    = 3'b001;
      tick();
      check_eq($sformatf("stream%0d_data", i), out_data, 64'h1000 + 64'(i));
      check_eq($sformatf("stream%0d_rd", i), out_rd, 64'(i + 1));
      check_eq($sformatf("stream%0d_valid", i), out_valid, 1);
      check_eq($sformatf("stream%0d_occ", i), occupancy, 1);
      check_eq($sformatf("stream%0d_inrdy", i), in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    check_eq("stream_drain_valid", out_valid, 0);
    check_eq("stream_drain_occ", occupancy, 0);

    // Backpressure, SKID=1.
    in_valid = 1'b1; in_data = 32'hA; in_rd = 5'd10; in_wb = 3'b001; out_ready = 1'b1;
    tick();
    check_eq("bp_a_data", out_data, 32'hA);
    out_ready = 1'b0; in_data = 32'hB; in_rd = 5'd11;
    tick();
    check_eq("bp_occ2", occupancy, 2);
    check_eq("bp_inrdy0", in_ready, 0);
    check_eq("bp_hold_a", out_data, 32'hA);
    in_data = 32'hC; in_rd = 5'd12;
    tick();
    check_eq("bp_still_occ2", occupancy, 2);
    check_eq("bp_still_a", out_data, 32'hA);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check_eq("bp_b_data", out_data, 32'hB);
    check_eq("bp_b_rd", out_rd, 11);
    check_eq("bp_b_occ", occupancy, 1);
    check_eq("bp_inrdy1", in_ready, 1);
    tick();
    check_eq("bp_empty", out_valid, 0);

    // x0 gating.
    in_valid = 1'b1; in_rd = 5'd0; in_wb = 3'b001; in_data = 32'h20;
    tick();
    check_eq("x0_eq0", out_rd_eq0, 1);
    check_eq("x0_rw", out_reg_write, 0);
    check_eq("x0_valid", out_valid, 1);
    in_rd = 5'd7; in_data = 32'h21;
    tick();
    check_eq("x7_eq0", out_rd_eq0, 0);
    check_eq("x7_rw", out_reg_write, 1);
    check_eq("x7_rd", out_rd, 7);
    in_valid = 1'b0;
    tick();
    check_eq("x_drain_rw", out_reg_write, 0);

    // Flush with both entries occupied and a beat offered.
    out_ready = 1'b0; in_valid = 1'b1; in_wb = 3'b001; in_rd = 5'd2; in_data = 32'h31;
    tick();
    in_data = 32'h32;
    tick();
    check_eq("fl_occ2", occupancy, 2);
    flush = 1'b1; in_data = 32'hDEAD;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("fl_valid", out_valid, 0);
    check_eq("fl_wb", out_wb, 0);
    check_eq("fl_occ", occupancy, 0);
    check_eq("fl_data_kept", out_data, 32'h31);
    out_ready = 1'b1;
    tick();
    check_eq("fl_no_dead_valid", out_valid, 0);
    check_eq("fl_no_dead_data", out_data, 32'h31);

    // Asynchronous reset between edges.
    in_valid = 1'b1; in_data = 32'h55; in_rd = 5'd3; in_wb = 3'b001; out_ready = 1'b0;
    tick();
    check_eq("ar_pre_data", out_data, 32'h55);
    check_eq("ar_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_reset("ar");
    in_data = 32'h66; in_rd = 5'd4; out_ready = 1'b1;
    #1 rst = 1'b0;
    tick();
    check_eq("ar_post_valid", out_valid, 1);
    check_eq("ar_post_data", out_data, 32'h66);
    check_eq("ar_post_rd", out_rd, 4);
    in_valid = 1'b0;
    tick();

    // SKID=0: combinational in_ready and bubble-free replacement.
    n_in_valid = 1'b1; n_in_data = 32'h70; n_in_rd = 5'd5; n_in_wb = 3'b001; n_out_ready = 1'b0;
    tick();
    check_eq("n_full_data", n_out_data, 32'h70);
    check_eq("n_full_occ", n_occupancy, 1);
    n_in_data = 32'h71; n_in_rd = 5'd6;
    #1;
    check_eq("n_inrdy0", n_in_ready, 0);
    tick();
    check_eq("n_hold_data", n_out_data, 32'h70);
    n_out_ready = 1'b1;
    #1;
    check_eq("n_inrdy1", n_in_ready, 1);
    tick();
    check_eq("n_repl_data", n_out_data, 32'h71);
    check_eq("n_repl_valid", n_out_valid, 1);
    check_eq("n_repl_rw", n_out_reg_write, 1);
    check_eq("n_repl_occ", n_occupancy, 1);
    n_in_valid = 1'b0;
    tick();
    check_eq("n_drain_valid", n_out_valid, 0);
    check_eq("n_drain_occ", n_occupancy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
